pass_sched: RTL and testbench
=============================

PASS_SCHED -- requirements
Module: pass_sched

Interface
REQ-001 SHALL provide parameter NEURONS, default 4, meaning jobs issued per pass (legal range 2..4).
REQ-002 SHALL provide port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port en_i  input  1  clock enable; when low, all registers hold.
REQ-005 SHALL provide port start_i  input  1  begin a training run; sampled in IDLE only.
REQ-006 SHALL provide port abort_i  input  1  terminate the run and return to IDLE.
REQ-007 SHALL provide port epochs_i  input  4  iterations per run; 0 treated as 1; sampled on start acceptance.
REQ-008 SHALL provide port mac_ready_i  input  1  shared MAC datapath can accept a job.
REQ-009 SHALL provide port mac_done_i  input  1  single-cycle pulse, MAC job complete.
REQ-010 SHALL provide port mac_valid_o  output  1  job request to the MAC datapath.
REQ-011 SHALL provide port neuron_idx_o  output  2  neuron index of current job.
REQ-012 SHALL provide ports f0_pass_o, f1_pass_o, b_pass_o  output  1 each  current-pass indicators.
REQ-013 SHALL provide port curr_state_o  output  3  encoded state.
REQ-014 SHALL provide port epoch_cnt_o  output  4  completed iterations in the current run.
REQ-015 SHALL provide ports busy_o  output  1  (state not IDLE) and done_o  output  1  (run complete pulse).

Function
REQ-016 SHALL implement states IDLE=000, F0=001, F1=010, BP=011, DONE=100; curr_state_o SHALL equal the state register; codes 101..111 SHALL return to IDLE on the next enabled edge.
REQ-017 SHALL decode f0_pass_o, f1_pass_o, b_pass_o from the state register, high exactly in F0, F1, BP respectively; at most one high at any time.
REQ-018 SHALL, in IDLE with start_i=1 and en_i=1, latch the target (epochs_i, 0->1), clear epoch_cnt_o and the neuron index, enter F0, and assert mac_valid_o from the next cycle.
REQ-019 SHALL, within each pass, run an ISSUE/WAIT sub-phase per neuron: ISSUE holds mac_valid_o=1 until a cycle with mac_valid_o, mac_ready_i and en_i all 1 (acceptance); WAIT holds mac_valid_o=0 until mac_done_i=1.
REQ-020 SHALL ignore mac_done_i while in ISSUE or outside F0/F1/BP.
REQ-021 SHALL, on mac_done_i in WAIT with neuron_idx_o < NEURONS-1, increment neuron_idx_o and re-enter ISSUE on the next cycle.
REQ-022 SHALL, on mac_done_i in WAIT with neuron_idx_o = NEURONS-1, reset neuron_idx_o to 0 and advance F0->F1, F1->BP, or leave BP, re-entering ISSUE.
REQ-023 SHALL, on leaving BP, increment epoch_cnt_o; if the new count equals the target, enter DONE, else enter F0.
REQ-024 SHALL spend exactly one cycle in DONE with done_o=1, then enter IDLE; epoch_cnt_o SHALL hold its final value until the next start.
REQ-025 SHALL give abort_i (with en_i=1) priority over all transitions: next state IDLE, mac_valid_o=0, neuron_idx_o=0, no done_o pulse.
REQ-026 SHALL ignore start_i outside IDLE; start_i and abort_i both high in IDLE SHALL leave the block in IDLE.
REQ-027 SHALL keep mac_valid_o and neuron_idx_o stable while en_i=0 or mac_ready_i=0 during ISSUE.
REQ-028 SHALL register mac_valid_o, neuron_idx_o, epoch_cnt_o and done_o (no combinational path from inputs).

Reset
REQ-029 SHALL, while rst_i=0 (asynchronously), force state IDLE, sub-phase ISSUE, neuron_idx_o=0, epoch_cnt_o=0, target=1, and mac_valid_o, done_o, busy_o and all pass flags 0.
REQ-030 SHALL, on reset mid-run, drop mac_valid_o immediately and restart only on a new start_i after rst_i=1.

Verification
REQ-031 SHALL cover: epochs_i=1, mac_ready_i=1, mac_done_i two cycles after each acceptance -> 12 jobs in order F0 n0..3, F1 n0..3, BP n0..3; one done_o pulse; epoch_cnt_o=1.
REQ-032 SHALL cover: epochs_i=0 -> behaves as 1; epochs_i=3 -> 36 accepted jobs, epoch_cnt_o steps 1,2,3, then DONE then IDLE.
REQ-033 SHALL cover: mac_ready_i low 5 cycles in ISSUE, plus en_i low 3 cycles -> mac_valid_o and neuron_idx_o held; no job lost or duplicated.
REQ-034 SHALL cover: spurious mac_done_i during ISSUE and in IDLE -> no index or state change.
REQ-035 SHALL cover: abort_i in F1 WAIT neuron 2 -> IDLE next cycle, mac_valid_o=0, no done_o; subsequent start_i runs cleanly.
REQ-036 SHALL cover: rst_i low asynchronously mid-BP -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/pass_sched.sv
// pass_sched: sequences a three-pass training run (F0, F1, BP) over NEURONS jobs
// each, handing one job at a time to a shared MAC datapath for a set number of epochs.
`default_nettype none

module pass_sched #(
  parameter int NEURONS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] epochs_i,
  input  logic       mac_ready_i,
  input  logic       mac_done_i,
  output logic       mac_valid_o,
  output logic [1:0] neuron_idx_o,
  output logic       f0_pass_o,
  output logic       f1_pass_o,
  output logic       b_pass_o,
  output logic [2:0] curr_state_o,
  output logic [3:0] epoch_cnt_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_F0   = 3'b001,
    ST_F1   = 3'b010,
    ST_BP   = 3'b011,
    ST_DONE = 3'b100
  } state_e;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_e;

  localparam logic [1:0] LAST_IDX = 2'(NEURONS - 1);

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] epoch_q, epoch_d;
  logic [3:0] target_q, target_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [3:0] epoch_inc;

  assign epoch_inc = epoch_q + 4'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_ISSUE;
      idx_q    <= 2'd0;
      epoch_q  <= 4'd0;
      target_q <= 4'd1;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    target_d = target_q;
    valid_d  = valid_q;
    done_d   = done_q;

    if (en_i) begin
      done_d = 1'b0;
      if (abort_i) begin
        state_d = ST_IDLE;
        phase_d = PH_ISSUE;
        idx_d   = 2'd0;
        valid_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            valid_d = 1'b0;
            if (start_i) begin
              target_d = (epochs_i == 4'd0) ? 4'd1 : epochs_i;
              epoch_d  = 4'd0;
              idx_d    = 2'd0;
              phase_d  = PH_ISSUE;
              state_d  = ST_F0;
              valid_d  = 1'b1;
            end
          end
          ST_F0, ST_F1, ST_BP: begin
            if (phase_q == PH_ISSUE) begin
              if (valid_q && mac_ready_i) begin
                phase_d = PH_WAIT;
                valid_d = 1'b0;
              end
            end else if (mac_done_i) begin
              phase_d = PH_ISSUE;
              valid_d = 1'b1;
              if (idx_q != LAST_IDX) begin
                idx_d = idx_q + 2'd1;
              end else begin
                idx_d = 2'd0;
                case (state_q)
                  ST_F0:   state_d = ST_F1;
                  ST_F1:   state_d = ST_BP;
                  default: begin
                    // End of backprop closes one epoch.
                    epoch_d = epoch_inc;
                    if (epoch_inc == target_q) begin
                      state_d = ST_DONE;
                      valid_d = 1'b0;
                      done_d  = 1'b1;
                    end else begin
                      state_d = ST_F0;
                    end
                  end
                endcase
              end
            end
          end
          ST_DONE: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
          default: begin
            state_d = ST_IDLE;
            phase_d = PH_ISSUE;
            idx_d   = 2'd0;
            valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  assign mac_valid_o  = valid_q;
  assign neuron_idx_o = idx_q;
  assign epoch_cnt_o  = epoch_q;
  assign done_o       = done_q;
  assign curr_state_o = state_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign f0_pass_o    = (state_q == ST_F0);
  assign f1_pass_o    = (state_q == ST_F1);
  assign b_pass_o     = (state_q == ST_BP);

endmodule

`default_nettype wire

// File: tb/tb_pass_sched.sv
// Directed bench for pass_sched: job ordering, epoch counting, stalls, abort and async reset.
`default_nettype none

module tb_pass_sched;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_F0   = 3'b001;
  localparam logic [2:0] S_F1   = 3'b010;
  localparam logic [2:0] S_BP   = 3'b011;
  localparam logic [2:0] S_DONE = 3'b100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       start_i;
  logic       abort_i;
  logic [3:0] epochs_i;
  logic       mac_ready_i;
  logic       mac_done_i;
  logic       mac_valid_o;
  logic [1:0] neuron_idx_o;
  logic       f0_pass_o;
  logic       f1_pass_o;
  logic       b_pass_o;
  logic [2:0] curr_state_o;
  logic [3:0] epoch_cnt_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;
  int jobs   = 0;

  pass_sched #(.NEURONS(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .epochs_i     (epochs_i),
    .mac_ready_i  (mac_ready_i),
    .mac_done_i   (mac_done_i),
    .mac_valid_o  (mac_valid_o),
    .neuron_idx_o (neuron_idx_o),
    .f0_pass_o    (f0_pass_o),
    .f1_pass_o    (f1_pass_o),
    .b_pass_o     (b_pass_o),
    .curr_state_o (curr_state_o),
    .epoch_cnt_o  (epoch_cnt_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, curr_state_o, S_IDLE);
    chk({tag, "_valid"}, mac_valid_o, 0);
    chk({tag, "_idx"},   neuron_idx_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_flags"}, {f0_pass_o, f1_pass_o, b_pass_o}, 0);
  endtask

  // One job: issue, accept, then mac_done two cycles after acceptance.
  task automatic do_job(input logic [2:0] st, input logic [1:0] idx);
    chk("job_valid", mac_valid_o, 1);
    chk("job_state", curr_state_o, st);
    chk("job_idx", neuron_idx_o, idx);
    chk("job_flags", {f0_pass_o, f1_pass_o, b_pass_o},
        (st == S_F0) ? 3'b100 : (st == S_F1) ? 3'b010 : 3'b001);
    chk("job_done_low", done_o, 0);
    mac_ready_i = 1'b1;
    @(negedge clk_i);
    mac_ready_i = 1'b0;
    jobs++;
    chk("wait_valid", mac_valid_o, 0);
    @(negedge clk_i);
    mac_done_i = 1'b1;
    @(negedge clk_i);
    mac_done_i = 1'b0;
  endtask

  task automatic run_pass(input logic [2:0] st);
    for (int i = 0; i < 4; i++) do_job(st, 2'(i));
  endtask

  task automatic run_epoch(input logic [3:0] exp_epoch);
    run_pass(S_F0);
    run_pass(S_F1);
    run_pass(S_BP);
    chk("epoch_cnt", epoch_cnt_o, exp_epoch);
  endtask

  task automatic start_run(input logic [3:0] ep);
    start_i  = 1'b1;
    epochs_i = ep;
    @(negedge clk_i);
    start_i  = 1'b0;
    epochs_i = 4'd7;
    chk("start_state", curr_state_o, S_F0);
    chk("start_valid", mac_valid_o, 1);
    chk("start_epoch", epoch_cnt_o, 0);
    chk("start_busy", busy_o, 1);
  endtask

  task automatic finish_run(input logic [3:0] exp_epoch);
    chk("done_state", curr_state_o, S_DONE);
    chk("done_pulse", done_o, 1);
    chk("done_valid", mac_valid_o, 0);
    chk("done_flags", {f0_pass_o, f1_pass_o, b_pass_o}, 0);
    @(negedge clk_i);
    chk_idle_outputs("post_done");
    chk("post_done_epoch", epoch_cnt_o, exp_epoch);
  endtask

  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    epochs_i    = 4'd0;
    mac_ready_i = 1'b0;
    mac_done_i  = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_epoch", epoch_cnt_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Spurious done and start+abort together in IDLE.
    mac_done_i = 1'b1;
    @(negedge clk_i);
    mac_done_i = 1'b0;
    chk_idle_outputs("idle_spurious");
    start_i = 1'b1;
    abort_i = 1'b1;
    epochs_i = 4'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk_idle_outputs("start_abort");

    // Single epoch: 12 jobs in order, one done pulse.
    jobs = 0;
    start_run(4'd1);
    run_epoch(4'd1);
    finish_run(4'd1);
    chk("jobs_1", jobs, 12);

    // Three epochs with stalls and a spurious done at the first issue.
    jobs = 0;
    start_run(4'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) mac_done_i = 1'b1;
      @(negedge clk_i);
      mac_done_i = 1'b0;
      chk("stall_ready_valid", mac_valid_o, 1);
      chk("stall_ready_idx", neuron_idx_o, 0);
      chk("stall_ready_state", curr_state_o, S_F0);
    end
    en_i = 1'b0;
    mac_ready_i = 1'b1;
    mac_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_en_valid", mac_valid_o, 1);
      chk("stall_en_idx", neuron_idx_o, 0);
      chk("stall_en_state", curr_state_o, S_F0);
    end
    mac_ready_i = 1'b0;
    mac_done_i = 1'b0;
    en_i = 1'b1;
    run_epoch(4'd1);
    chk("ep1_state", curr_state_o, S_F0);
    run_epoch(4'd2);
    chk("ep2_state", curr_state_o, S_F0);
    run_epoch(4'd3);
    finish_run(4'd3);
    chk("jobs_3", jobs, 36);

    // Zero epochs behaves as one.
    jobs = 0;
    start_run(4'd0);
    run_epoch(4'd1);
    finish_run(4'd1);
    chk("jobs_0", jobs, 12);

    // Abort while waiting on F1 neuron 2.
    start_run(4'd2);
    run_pass(S_F0);
    do_job(S_F1, 2'd0);
    do_job(S_F1, 2'd1);
    chk("abort_pre_idx", neuron_idx_o, 2);
    mac_ready_i = 1'b1;
    @(negedge clk_i);
    mac_ready_i = 1'b0;
    chk("abort_pre_wait", mac_valid_o, 0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk_idle_outputs("abort");
    @(negedge clk_i);
    chk("abort_no_done", done_o, 0);
    jobs = 0;
    start_run(4'd1);
    run_epoch(4'd1);
    finish_run(4'd1);
    chk("jobs_after_abort", jobs, 12);

    // Asynchronous reset mid-BP.
    start_run(4'd1);
    run_pass(S_F0);
    run_pass(S_F1);
    do_job(S_BP, 2'd0);
    chk("rst_pre_state", curr_state_o, S_BP);
    #2 rst_i = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_epoch", epoch_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk_idle_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
